// File: rtl/mem_hit_arbiter.sv
// Single-port RAM arbiter: serializes fetch and load/store requests, data first.
// Optional ARB_FAIRNESS_EN forces an instruction grant after STARVE_MAX data grants.
module mem_hit_arbiter #(
   parameter int unsigned LAT        = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        ihit,
   output logic        dhit,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload
);

   localparam int unsigned CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {StIdle, StIacc, StDacc, StResp} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            r_is_wr;
   logic            w_is_wr_next;
   logic            r_ihit;
   logic            r_dhit;
   logic            w_ihit_next;
   logic            w_dhit_next;
   logic [31:0]     r_iload;
   logic [31:0]     r_dload;
   logic            w_cap_i;
   logic            w_cap_d;
   logic            r_ramren;
   logic            r_ramwen;
   logic            w_ramren_next;
   logic            w_ramwen_next;
   logic [31:0]     r_ramaddr;
   logic [31:0]     r_ramstore;
   logic [31:0]     w_ramaddr_next;
   logic [31:0]     w_ramstore_next;
   logic            w_data_req;
   logic            w_grant_i;
   logic            w_grant_d;
   logic            w_abort;
   logic            w_last;

   assign w_data_req = dREN | dWEN;
   assign w_last     = (r_cnt == '0);

`ifdef ARB_FAIRNESS_EN
   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [SW-1:0] r_starve;
   logic          w_force_i;

   assign w_force_i = iREN && (r_starve >= SW'(STARVE_MAX));
   assign w_grant_d = w_data_req && !w_force_i;
   assign w_grant_i = iREN && !w_grant_d;

   // Counts only data grants that bypassed a waiting fetch; saturates at STARVE_MAX.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_starve <= '0;
      end else if (r_state == StIdle) begin
         if (!iREN || w_grant_i) begin
            r_starve <= '0;
         end else if (w_grant_d && (r_starve < SW'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end
`else
   assign w_grant_d = w_data_req;
   assign w_grant_i = iREN && !w_data_req;
`endif

   // Only reads can be aborted; a write runs to completion regardless of dWEN.
   always_comb begin
      w_abort = 1'b0;
      if (r_state == StIacc) begin
         w_abort = !iREN;
      end else if (r_state == StDacc) begin
         w_abort = !r_is_wr && !dREN;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_is_wr_next    = r_is_wr;
      w_ramaddr_next  = r_ramaddr;
      w_ramstore_next = r_ramstore;
      w_ihit_next     = 1'b0;
      w_dhit_next     = 1'b0;
      w_cap_i         = 1'b0;
      w_cap_d         = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_grant_d) begin
               w_state_next    = StDacc;
               w_cnt_next      = CW'(LAT - 1);
               w_is_wr_next    = dWEN;
               w_ramaddr_next  = daddr;
               w_ramstore_next = dstore;
            end else if (w_grant_i) begin
               w_state_next   = StIacc;
               w_cnt_next     = CW'(LAT - 1);
               w_is_wr_next   = 1'b0;
               w_ramaddr_next = iaddr;
            end
         end
         StIacc, StDacc: begin
            if (w_abort) begin
               w_state_next = StIdle;
               w_cnt_next   = '0;
            end else if (w_last) begin
               w_state_next = StResp;
               if (r_state == StIacc) begin
                  w_ihit_next = 1'b1;
                  w_cap_i     = 1'b1;
               end else begin
                  w_dhit_next = 1'b1;
                  w_cap_d     = !r_is_wr;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         StResp: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Strobes are registered from the next state so they line up with the ACC cycles.
   always_comb begin
      w_ramren_next = 1'b0;
      w_ramwen_next = 1'b0;
      if (w_state_next == StIacc) begin
         w_ramren_next = 1'b1;
      end else if (w_state_next == StDacc) begin
         w_ramren_next = !w_is_wr_next;
         w_ramwen_next = w_is_wr_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_is_wr    <= 1'b0;
         r_ihit     <= 1'b0;
         r_dhit     <= 1'b0;
         r_iload    <= '0;
         r_dload    <= '0;
         r_ramren   <= 1'b0;
         r_ramwen   <= 1'b0;
         r_ramaddr  <= '0;
         r_ramstore <= '0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_is_wr    <= w_is_wr_next;
         r_ihit     <= w_ihit_next;
         r_dhit     <= w_dhit_next;
         r_ramren   <= w_ramren_next;
         r_ramwen   <= w_ramwen_next;
         r_ramaddr  <= w_ramaddr_next;
         r_ramstore <= w_ramstore_next;
         if (w_cap_i) begin
            r_iload <= ramload;
         end
         if (w_cap_d) begin
            r_dload <= ramload;
         end
      end
   end

   assign ihit     = r_ihit;
   assign dhit     = r_dhit;
   assign iload    = r_iload;
   assign dload    = r_dload;
   assign ramREN   = r_ramren;
   assign ramWEN   = r_ramwen;
   assign ramaddr  = r_ramaddr;
   assign ramstore = r_ramstore;

endmodule

// File: tb/tb_mem_hit_arbiter.sv
// Scoreboard bench for mem_hit_arbiter: directed requests push expected hits,
// a negedge monitor pops and compares kind, load data and arrival cycle.
module tb_mem_hit_arbiter;

   localparam int unsigned LAT = 2;

   logic        CLK    = 1'b0;
   logic        RST    = 1'b1;
   logic        iREN   = 1'b0;
   logic        dREN   = 1'b0;
   logic        dWEN   = 1'b0;
   logic [31:0] iaddr  = '0;
   logic [31:0] daddr  = '0;
   logic [31:0] dstore = '0;
   logic        ihit;
   logic        dhit;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;

   mem_hit_arbiter #(
      .LAT        (LAT),
      .STARVE_MAX (4)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .ihit     (ihit),
      .dhit     (dhit),
      .iload    (iload),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // RAM model: fixed contents plus whatever has been written.
   bit          wv [256];
   logic [31:0] wm [256];

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h40:  return 32'h8C01_0004;
         32'h44:  return 32'h2002_0005;
         32'h200: return 32'h1234_5678;
         default: return ~a;
      endcase
   endfunction

   always_comb begin
      ramload = rom(ramaddr);
      if (wv[ramaddr[9:2]]) ramload = wm[ramaddr[9:2]];
   end

   always @(posedge CLK) begin
      if (ramWEN) begin
         wv[ramaddr[9:2]] <= 1'b1;
         wm[ramaddr[9:2]] <= ramstore;
      end
   end

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic expect_hit(input bit is_d, input logic [31:0] d, input int at);
      exp_t e;
      e.is_d = is_d;
      e.data = d;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ihit"},     {31'b0, ihit},   32'h0);
      chk({tag, "_dhit"},     {31'b0, dhit},   32'h0);
      chk({tag, "_ramREN"},   {31'b0, ramREN}, 32'h0);
      chk({tag, "_ramWEN"},   {31'b0, ramWEN}, 32'h0);
      chk({tag, "_iload"},    iload,           32'h0);
      chk({tag, "_dload"},    dload,           32'h0);
      chk({tag, "_ramaddr"},  ramaddr,         32'h0);
      chk({tag, "_ramstore"}, ramstore,        32'h0);
   endtask

   always @(negedge CLK) begin
      if (!RST && (ihit || dhit)) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_hit: got ihit=%b dhit=%b at cycle %0d, expected none",
                     ihit, dhit, cyc);
         end else begin
            e = sb.pop_front();
            chk("hit_kind", {30'b0, ihit, dhit}, e.is_d ? 32'h1 : 32'h2);
            chk("hit_data", e.is_d ? dload : iload, e.data);
            chk("hit_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      int c;
      tick(3);
      chk_zero("reset");
      RST = 1'b0;
      tick();

      // Plain fetch; iaddr changes mid-flight and must not matter.
      c = cyc; iREN = 1'b1; iaddr = 32'h40;
      expect_hit(1'b0, 32'h8C01_0004, c + 3);
      tick();
      chk("f_ren1", {31'b0, ramREN}, 32'h1);
      chk("f_wen1", {31'b0, ramWEN}, 32'h0);
      chk("f_addr1", ramaddr, 32'h40);
      iaddr = 32'h999;
      tick();
      chk("f_ren2", {31'b0, ramREN}, 32'h1);
      chk("f_addr2", ramaddr, 32'h40);
      tick();
      chk("f_ren_resp", {31'b0, ramREN}, 32'h0);
      iREN = 1'b0;
      tick(2);

      // Data write beats a simultaneous fetch; fetch follows.
      c = cyc; iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
      expect_hit(1'b1, 32'h0, c + 3);
      expect_hit(1'b0, 32'h2002_0005, c + 7);
      tick();
      chk("w_wen1", {31'b0, ramWEN}, 32'h1);
      chk("w_ren1", {31'b0, ramREN}, 32'h0);
      chk("w_addr", ramaddr, 32'h100);
      chk("w_store", ramstore, 32'hDEAD_BEEF);
      tick();
      chk("w_wen2", {31'b0, ramWEN}, 32'h1);
      tick();
      dWEN = 1'b0;
      tick();
      chk("w_idle_ren", {31'b0, ramREN}, 32'h0);
      tick();
      chk("w_i_ren", {31'b0, ramREN}, 32'h1);
      chk("w_i_addr", ramaddr, 32'h44);
      tick(2);
      iREN = 1'b0;
      tick(2);

      // Read back the written word.
      c = cyc; dREN = 1'b1; daddr = 32'h100;
      expect_hit(1'b1, 32'hDEAD_BEEF, c + 3);
      tick(3);
      dREN = 1'b0;
      tick(2);

      // Fetch flushed in its first ACC cycle.
      c = cyc; iREN = 1'b1; iaddr = 32'h200;
      tick();
      chk("ab_ren", {31'b0, ramREN}, 32'h1);
      iREN = 1'b0;
      tick();
      chk("ab_ren_off", {31'b0, ramREN}, 32'h0);
      tick(4);
      chk("ab_iload", iload, 32'h2002_0005);

      // Reset in the middle of a data read, then a fresh read.
      c = cyc; dREN = 1'b1; daddr = 32'h44;
      tick();
      chk("rs_ren", {31'b0, ramREN}, 32'h1);
      RST = 1'b1;
      tick();
      chk_zero("midrst");
      RST = 1'b0;
      expect_hit(1'b1, 32'h2002_0005, c + 5);
      tick(3);
      dREN = 1'b0;
      tick(2);

      // Write whose dWEN drops mid-access still completes.
      c = cyc; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hCAFE_F00D;
      expect_hit(1'b1, 32'h2002_0005, c + 3);
      tick();
      dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
      tick();
      chk("wd_wen", {31'b0, ramWEN}, 32'h1);
      chk("wd_addr", ramaddr, 32'h300);
      chk("wd_store", ramstore, 32'hCAFE_F00D);
      tick();
      chk("wd_wen_off", {31'b0, ramWEN}, 32'h0);
      tick(2);
      c = cyc; dREN = 1'b1; daddr = 32'h300;
      expect_hit(1'b1, 32'hCAFE_F00D, c + 3);
      tick(3);
      dREN = 1'b0;
      tick(2);

      // Data and fetch held together.
      c = cyc; dREN = 1'b1; daddr = 32'h40; iREN = 1'b1; iaddr = 32'h200;
`ifdef ARB_FAIRNESS_EN
      for (int k = 0; k < 4; k++) expect_hit(1'b1, 32'h8C01_0004, c + 3 + 4 * k);
      expect_hit(1'b0, 32'h1234_5678, c + 19);
      tick(19);
      dREN = 1'b0;
      iREN = 1'b0;
      tick(3);
`else
      for (int k = 0; k < 5; k++) expect_hit(1'b1, 32'h8C01_0004, c + 3 + 4 * k);
      expect_hit(1'b0, 32'h1234_5678, c + 23);
      tick(19);
      dREN = 1'b0;
      tick(4);
      iREN = 1'b0;
      tick(3);
`endif

      chk("sb_drained", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog");
   end

endmodule
